// File: rtl/axi_pwm_array.sv
// Purpose: NCH-channel PWM generator behind an AXI4-Lite slave, one shared period counter.
// Latency: write BVALID 2 cycles after AW+W together; RVALID 1 cycle after AR; pwm registered.
// Backpressure: one captured AW and one W beat; AW/W/AR ready held low until the B/R handshake.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   saxi_AW*/W*/B*           AXI4-Lite write address/data/response (full-word writes, OKAY only)
//   saxi_AR*/R*              AXI4-Lite read address/data
//   pwm[NCH-1:0]             registered PWM outputs
//
// Register window (byte offsets from BaseAddr): 0x00 CTRL.EN, 0x04 PERIOD (pending),
// 0x08 POL, 0x0C COUNT (RO), 0x10+4*i DUTY[i] (pending). Everything else reads 0, ignores writes.
module axi_pwm_array #(
  parameter int unsigned NCH      = 4,
  parameter int unsigned CW       = 16,
  parameter logic [31:0] BaseAddr = 32'h4000_0000
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic           saxi_AWVALID,
  output logic           saxi_AWREADY,
  input  logic [31:0]    saxi_AWADDR,
  input  logic           saxi_WVALID,
  output logic           saxi_WREADY,
  input  logic [31:0]    saxi_WDATA,
  output logic           saxi_BVALID,
  input  logic           saxi_BREADY,
  input  logic           saxi_ARVALID,
  output logic           saxi_ARREADY,
  input  logic [31:0]    saxi_ARADDR,
  output logic           saxi_RVALID,
  input  logic           saxi_RREADY,
  output logic [31:0]    saxi_RDATA,
  output logic [NCH-1:0] pwm
);

  // Holds the readies low until the first edge after reset release.
  logic r_rdy_en;

  // Write channel state
  logic        r_aw_held;
  logic [31:0] r_aw_addr;
  logic        r_w_held;
  logic [31:0] r_w_data;
  logic        r_bvalid;

  // Read channel state
  logic        r_rvalid;
  logic [31:0] r_rdata;

  // Programmable registers (pending copies for period/duty)
  logic           r_en;
  logic [CW-1:0]  r_period;
  logic [NCH-1:0] r_pol;
  logic [CW-1:0]  r_duty [NCH];

  // Active (shadow) copies and the shared counter
  logic [CW-1:0]  r_period_act;
  logic [CW-1:0]  r_duty_act [NCH];
  logic [CW-1:0]  r_cnt;
  logic [NCH-1:0] r_pwm;

  logic        w_awrdy;
  logic        w_wrdy;
  logic        w_arrdy;
  logic        w_commit;
  logic [31:0] w_wr_off;
  logic        w_wr_map;
  logic [5:0]  w_wr_idx;
  logic [31:0] w_rd_off;
  logic        w_rd_map;
  logic [5:0]  w_rd_idx;
  logic [31:0] w_rd_val;
  logic        w_wrap;
  logic        w_load;
  logic        w_unused_wdata;

  // ------------------------------------------------------------------
  // Handshake readies
  // ------------------------------------------------------------------
  assign w_awrdy  = r_rdy_en & ~r_aw_held & ~r_bvalid;
  assign w_wrdy   = r_rdy_en & ~r_w_held & ~r_bvalid;
  assign w_arrdy  = r_rdy_en & ~r_rvalid;
  assign w_commit = r_aw_held & r_w_held;

  // ------------------------------------------------------------------
  // Address decode: mapped only inside the 256-byte window and word aligned.
  // The subtraction wraps for addresses below BaseAddr, which lands them outside the window.
  // ------------------------------------------------------------------
  assign w_wr_off = r_aw_addr - BaseAddr;
  assign w_wr_map = (w_wr_off[31:8] == 24'd0) && (w_wr_off[1:0] == 2'd0);
  assign w_wr_idx = w_wr_off[7:2];

  assign w_rd_off = saxi_ARADDR - BaseAddr;
  assign w_rd_map = (w_rd_off[31:8] == 24'd0) && (w_rd_off[1:0] == 2'd0);
  assign w_rd_idx = w_rd_off[7:2];

  // Only the low field bits of a write are stored into registers.
  assign w_unused_wdata = ^r_w_data;

  // ------------------------------------------------------------------
  // Write channel: independent AW/W capture, commit when both are held
  // ------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rdy_en  <= 1'b0;
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_bvalid  <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_awrdy && saxi_AWVALID) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= saxi_AWADDR;
      end
      if (w_wrdy && saxi_WVALID) begin
        r_w_held <= 1'b1;
        r_w_data <= saxi_WDATA;
      end
      // Readies are low while both beats are held, so commit never races a new capture.
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
      end else if (r_bvalid && saxi_BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------
  // Register file update on commit
  // ------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_en     <= 1'b0;
      r_period <= '0;
      r_pol    <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_duty[i] <= '0;
      end
    end else if (w_commit && w_wr_map) begin
      case (w_wr_idx)
        6'd0:    r_en     <= r_w_data[0];
        6'd1:    r_period <= r_w_data[CW-1:0];
        6'd2:    r_pol    <= r_w_data[NCH-1:0];
        default: ;
      endcase
      for (int i = 0; i < NCH; i++) begin
        if (w_wr_idx == 6'(4 + i)) begin
          r_duty[i] <= r_w_data[CW-1:0];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Read channel
  // ------------------------------------------------------------------
  always_comb begin
    w_rd_val = '0;
    if (w_rd_map) begin
      case (w_rd_idx)
        6'd0:    w_rd_val = 32'(r_en);
        6'd1:    w_rd_val = 32'(r_period);
        6'd2:    w_rd_val = 32'(r_pol);
        6'd3:    w_rd_val = 32'(r_cnt);
        default: w_rd_val = '0;
      endcase
      for (int i = 0; i < NCH; i++) begin
        if (w_rd_idx == 6'(4 + i)) begin
          w_rd_val = 32'(r_duty[i]);
        end
      end
    end
  end

  // Read data is sampled from register state before any same-edge write commit lands.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else if (w_arrdy && saxi_ARVALID) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_val;
    end else if (r_rvalid && saxi_RREADY) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end
  end

  // ------------------------------------------------------------------
  // Counter, shadow load and outputs
  // ------------------------------------------------------------------
  assign w_wrap = (r_cnt == r_period_act);
  // Shadows follow the pending copies continuously while disabled, and only at the wrap
  // while running, so a period is never cut short or stretched by a mid-period write.
  assign w_load = ~r_en | w_wrap;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt        <= '0;
      r_period_act <= '0;
      r_pwm        <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_duty_act[i] <= '0;
      end
    end else begin
      if (!r_en || w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_load) begin
        r_period_act <= r_period;
        for (int i = 0; i < NCH; i++) begin
          r_duty_act[i] <= r_duty[i];
        end
      end
      for (int i = 0; i < NCH; i++) begin
        r_pwm[i] <= r_pol[i] ^ (r_en & (r_cnt < r_duty_act[i]));
      end
    end
  end

  assign saxi_AWREADY = w_awrdy;
  assign saxi_WREADY  = w_wrdy;
  assign saxi_BVALID  = r_bvalid;
  assign saxi_ARREADY = w_arrdy;
  assign saxi_RVALID  = r_rvalid;
  assign saxi_RDATA   = r_rdata;
  assign pwm          = r_pwm;

endmodule

// File: tb/tb_axi_pwm_array.sv
// Bench for axi_pwm_array: directed bus/timing steps plus randomized PWM configurations.
// Expected pwm behaviour comes from per-period arithmetic (high time = min(duty, period+1),
// inverted by polarity; rising edges one period apart), not from a cycle model of the RTL.
module tb_axi_pwm_array;
  localparam int NCH = 4;
  localparam int CW  = 16;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic           aclk = 1'b0;
  logic           aresetn;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rvalid, rready;
  logic [31:0]    awaddr, wdata, araddr, rdata;
  logic [NCH-1:0] pwm;

  int n_tests = 0;
  int n_fail  = 0;
  int b_hs    = 0;
  bit rec     = 1'b0;
  int cur_run = 0;
  int runs[$];

  // Reference model state
  int             m_period;
  logic [NCH-1:0] m_pol;
  int             m_duty [NCH];

  always #5 aclk = ~aclk;

  axi_pwm_array #(.NCH(NCH), .CW(CW), .BaseAddr(BASE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .saxi_AWVALID(awvalid), .saxi_AWREADY(awready), .saxi_AWADDR(awaddr),
    .saxi_WVALID(wvalid), .saxi_WREADY(wready), .saxi_WDATA(wdata),
    .saxi_BVALID(bvalid), .saxi_BREADY(bready),
    .saxi_ARVALID(arvalid), .saxi_ARREADY(arready), .saxi_ARADDR(araddr),
    .saxi_RVALID(rvalid), .saxi_RREADY(rready), .saxi_RDATA(rdata),
    .pwm(pwm)
  );

  // Count completed B handshakes.
  always @(posedge aclk) begin
    if (aresetn && bvalid && bready) b_hs <= b_hs + 1;
  end

  // Record completed high-run lengths of pwm[0].
  always @(negedge aclk) begin
    if (rec) begin
      if (pwm[0]) cur_run <= cur_run + 1;
      else if (cur_run > 0) begin
        runs.push_back(cur_run);
        cur_run <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data);
    bit a_done = 0, w_done = 0, a_hs, w_hs;
    int n = 0;
    @(negedge aclk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wvalid = 1'b1;
    while (!(a_done && w_done) && n < 20) begin
      a_hs = awvalid & awready;
      w_hs = wvalid & wready;
      @(negedge aclk);
      if (a_hs) begin awvalid = 1'b0; a_done = 1; end
      if (w_hs) begin wvalid = 1'b0; w_done = 1; end
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    chk("wr_handshake", {30'd0, a_done & w_done, bvalid}, 32'd3);
    @(negedge aclk);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int n = 0;
    @(negedge aclk);
    araddr = addr; arvalid = 1'b1;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge aclk); n++; end
    chk("rd_handshake", 32'(rvalid), 32'd1);
    data = rdata;
    @(negedge aclk);
  endtask

  // Measures high time and period of every channel against the model.
  task automatic measure(input string tag);
    int L;
    int hi [NCH];
    int r1 [NCH];
    int r2 [NCH];
    int act, exp_hi;
    logic [NCH-1:0] prev;
    logic [31:0] c;
    L = m_period + 1;
    repeat (2 * L + 4) @(negedge aclk);
    prev = pwm;
    for (int i = 0; i < NCH; i++) begin hi[i] = 0; r1[i] = -1; r2[i] = -1; end
    for (int t = 0; t < 3 * L; t++) begin
      @(negedge aclk);
      for (int i = 0; i < NCH; i++) begin
        if (t < 2 * L && pwm[i]) hi[i]++;
        if (pwm[i] && !prev[i]) begin
          if (r1[i] < 0) r1[i] = t;
          else if (r2[i] < 0) r2[i] = t;
        end
      end
      prev = pwm;
    end
    for (int i = 0; i < NCH; i++) begin
      act    = (m_duty[i] < L) ? m_duty[i] : L;
      exp_hi = m_pol[i] ? (L - act) : act;
      chk({tag, "_high_time"}, 32'(hi[i]), 32'(2 * exp_hi));
      if (act > 0 && act < L) chk({tag, "_period"}, 32'(r2[i] - r1[i]), 32'(L));
    end
    for (int k = 0; k < 3; k++) begin
      axi_read(BASE + 32'h0C, c);
      chk({tag, "_count_range"}, 32'(c <= 32'(m_period)), 32'd1);
    end
  endtask

  task automatic program_model(input bit junk);
    logic [31:0] hi_junk;
    hi_junk = junk ? $urandom : 32'd0;
    axi_write(BASE + 32'h00, 32'd0);
    axi_write(BASE + 32'h04, (hi_junk & 32'hFFFF_0000) | 32'(m_period));
    axi_write(BASE + 32'h08, (hi_junk & 32'hFFFF_FFF0) | 32'(m_pol));
    for (int i = 0; i < NCH; i++)
      axi_write(BASE + 32'h10 + 32'(4 * i), (hi_junk & 32'hFFFF_0000) | 32'(m_duty[i]));
    axi_write(BASE + 32'h00, (hi_junk & 32'hFFFF_FFFE) | 32'd1);
  endtask

  initial begin
    logic [31:0] v;
    int n;
    int b0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = 0; wdata = 0; araddr = 0;
    aresetn = 1'b1;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    #1 chk("rel_readies_low", {29'd0, awready, wready, arready}, 32'd0);
    @(negedge aclk);
    chk("rel_readies_high", {29'd0, awready, wready, arready}, 32'd7);
    axi_read(BASE + 32'h00, v); chk("rst_ctrl", v, 32'd0);
    axi_read(BASE + 32'h04, v); chk("rst_period", v, 32'd0);
    axi_read(BASE + 32'h08, v); chk("rst_pol", v, 32'd0);
    axi_read(BASE + 32'h0C, v); chk("rst_count", v, 32'd0);
    axi_read(BASE + 32'h10, v); chk("rst_duty0", v, 32'd0);

    // Directed configuration: period 10, duties 3/0/10/5.
    m_period = 9; m_pol = '0;
    m_duty[0] = 3; m_duty[1] = 0; m_duty[2] = 10; m_duty[3] = 5;
    program_model(1'b0);
    measure("base");

    // Duty change mid-period: the running 3-cycle pulse finishes, then 7-cycle pulses follow.
    n = 0;
    while (pwm[0] && n < 40) begin @(negedge aclk); n++; end
    rec = 1'b1;
    n = 0;
    while (!pwm[0] && n < 40) begin @(negedge aclk); n++; end
    axi_write(BASE + 32'h10, 32'd7);
    m_duty[0] = 7;
    repeat (40) @(negedge aclk);
    rec = 1'b0;
    chk("dchg_nruns_ok", 32'(runs.size() >= 3), 32'd1);
    if (runs.size() > 0) chk("dchg_first_run", 32'(runs[0]), 32'd3);
    for (int k = 1; k < runs.size(); k++) chk("dchg_later_run", 32'(runs[k]), 32'd7);

    // W three cycles ahead of AW, BREADY held low for five cycles.
    b0 = b_hs;
    bready = 1'b0;
    @(negedge aclk);
    wdata = 32'h0000_1234; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    chk("wfirst_wready_low", 32'(wready), 32'd0);
    @(negedge aclk);
    chk("wfirst_awready_high", 32'(awready), 32'd1);
    @(negedge aclk);
    awaddr = BASE + 32'h14; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 10) begin @(negedge aclk); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("wfirst_hold", {29'd0, bvalid, awready, wready}, 32'd4);
      @(negedge aclk);
    end
    bready = 1'b1;
    @(negedge aclk);
    chk("wfirst_bdone", 32'(bvalid), 32'd0);
    @(negedge aclk);
    chk("wfirst_ready_back", {30'd0, awready, wready}, 32'd3);
    chk("wfirst_one_commit", 32'(b_hs - b0), 32'd1);
    axi_read(BASE + 32'h14, v); chk("wfirst_duty1", v, 32'h1234);

    // Randomized configurations, with junk in the upper write bits.
    for (int it = 0; it < 5; it++) begin
      int ch;
      m_period = int'($urandom_range(1, 20));
      m_pol    = NCH'($urandom_range(0, 15));
      for (int i = 0; i < NCH; i++) m_duty[i] = int'($urandom_range(0, m_period + 2));
      program_model(1'b1);
      axi_read(BASE + 32'h00, v); chk("rand_ctrl", v, 32'd1);
      axi_read(BASE + 32'h04, v); chk("rand_period", v, 32'(m_period));
      axi_read(BASE + 32'h08, v); chk("rand_pol", v, 32'(m_pol));
      ch = int'($urandom_range(0, NCH - 1));
      axi_read(BASE + 32'h10 + 32'(4 * ch), v); chk("rand_duty", v, 32'(m_duty[ch]));
      measure("rand");
    end

    // Polarity with the counter disabled.
    axi_write(BASE + 32'h00, 32'd0);
    axi_write(BASE + 32'h08, 32'h0000_000F);
    chk("pol_out", 32'(pwm), 32'hF);

    // Unmapped accesses.
    axi_read(BASE + 32'h80, v); chk("unmap_rd_80", v, 32'd0);
    axi_read(BASE + 32'h20, v); chk("unmap_rd_duty4", v, 32'd0);
    axi_write(BASE + 32'h80, 32'hFFFF_FFFF);
    axi_write(BASE + 32'h05, 32'hFFFF_FFFF);
    axi_write(BASE - 32'h4, 32'hFFFF_FFFF);
    axi_write(BASE + 32'h100, 32'hFFFF_FFFF);
    axi_read(BASE + 32'h00, v); chk("unmap_ctrl_kept", v, 32'd0);
    axi_read(BASE + 32'h04, v); chk("unmap_period_kept", v, 32'(m_period));
    axi_read(BASE + 32'h08, v); chk("unmap_pol_kept", v, 32'hF);
    axi_read(BASE + 32'h10, v); chk("unmap_duty0_kept", v, 32'(m_duty[0]));

    // Reset while a read response is pending.
    rready = 1'b0;
    @(negedge aclk);
    araddr = BASE + 32'h08; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge aclk); n++; end
    chk("rstmid_rvalid_pre", 32'(rvalid), 32'd1);
    chk("rstmid_rdata_pre", rdata, 32'hF);
    #2 aresetn = 1'b0;
    #1;
    chk("rstmid_rvalid", 32'(rvalid), 32'd0);
    chk("rstmid_rdata", rdata, 32'd0);
    chk("rstmid_pwm", 32'(pwm), 32'd0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    rready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rstmid_pwm_after", 32'(pwm), 32'd0);
    axi_read(BASE + 32'h00, v); chk("rstmid_ctrl", v, 32'd0);
    axi_read(BASE + 32'h04, v); chk("rstmid_period", v, 32'd0);
    axi_read(BASE + 32'h08, v); chk("rstmid_pol", v, 32'd0);
    axi_read(BASE + 32'h10, v); chk("rstmid_duty0", v, 32'd0);
    axi_read(BASE + 32'h0C, v); chk("rstmid_count", v, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
